// File: rtl/seg_disp_pkg.sv
// Shared 7-segment glyph constants, scan positions and decode helpers.
// The display driver and the scan-bus readback monitor both use this package.
package seg_disp_pkg;

    localparam int NPOS = 6;

    // Segment glyphs, bits ordered a..g with a as the MSB.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_S = SEG_5;

    localparam logic [5:0] POS1 = 6'b000001;
    localparam logic [5:0] POS2 = 6'b000010;
    localparam logic [5:0] POS3 = 6'b000100;
    localparam logic [5:0] POS4 = 6'b001000;
    localparam logic [5:0] POS5 = 6'b010000;
    localparam logic [5:0] POS6 = 6'b100000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } frame_state_e;

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        case (pat)
            SEG_0:   return 4'd0;
            SEG_1:   return 4'd1;
            SEG_2:   return 4'd2;
            SEG_3:   return 4'd3;
            SEG_4:   return 4'd4;
            SEG_5:   return 4'd5;
            SEG_6:   return 4'd6;
            SEG_7:   return 4'd7;
            SEG_8:   return 4'd8;
            SEG_9:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic sel_is_onehot(input logic [5:0] sel);
        return (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [2:0] sel_to_idx(input logic [5:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NPOS; i++) begin
            if (sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed 7-segment scan bus: one-hot digit select plus segment pattern.
// The display driver is the master; readback monitors attach as slaves.
interface seg_scan_decoder_if;
    logic [5:0] scan_sel_in;
    logic [7:0] seg_in;

    modport master (output scan_sel_in, output seg_in);
    modport slave  (input  scan_sel_in, input  seg_in);
endinterface

// File: rtl/seg_bus_sampler.sv
// Synchronises the asynchronous scan bus and emits one capture strobe per
// value that has stayed unchanged for STABLE_CYC cycles.
module seg_bus_sampler #(
    parameter int STABLE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_all,
    input  logic [5:0] sel_i,
    input  logic [7:0] seg_i,
    output logic       cap_stb_o,
    output logic [5:0] cap_sel_o,
    output logic [7:0] cap_seg_o
);
    localparam int               CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(STABLE_CYC);
    localparam logic [CW-1:0]    CNT_CAP = CW'(STABLE_CYC - 1);

    logic [13:0]   sync1_q, sync2_q, last_q;
    logic [CW-1:0] stab_cnt_q, stab_cnt_d;

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (sync2_q != last_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            last_q     <= '0;
            stab_cnt_q <= '0;
        end else begin
            sync1_q    <= {sel_i, seg_i};
            sync2_q    <= sync1_q;
            last_q     <= sync2_q;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Saturation above CNT_CAP keeps the strobe to a single cycle per value.
    assign cap_stb_o              = (stab_cnt_q == CNT_CAP);
    assign {cap_sel_o, cap_seg_o} = last_q;

endmodule

// File: rtl/seg_scan_decoder.sv
// Scan-bus readback monitor: decodes stable digit positions to BCD and
// commits complete, in-order 6-digit frames with change/sequence/link status.
//
// state      | meaning
// ST_IDLE    | no frame in progress; waiting for a position-1 capture
// ST_COLLECT | storing positions in order; exp_idx is the next one expected
module seg_scan_decoder
    import seg_disp_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst_all,
    seg_scan_decoder_if.slave    bus,
    output logic [23:0]          digits_o,
    output logic [5:0]           dp_o,
    output logic [5:0]           bad_code_o,
    output logic                 frame_valid_o,
    output logic                 changed_o,
    output logic                 seq_err_o,
    output logic                 link_lost_o
);
    localparam int          TO_W   = 17;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_HIT = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAST_IDX = 3'(NPOS - 1);

    logic       cap_stb;
    logic [5:0] cap_sel;
    logic [7:0] cap_seg;

    seg_bus_sampler #(.STABLE_CYC(STABLE_CYC)) u_sampler (
        .clk       (clk),
        .rst_all   (rst_all),
        .sel_i     (bus.scan_sel_in),
        .seg_i     (bus.seg_in),
        .cap_stb_o (cap_stb),
        .cap_sel_o (cap_sel),
        .cap_seg_o (cap_seg)
    );

    frame_state_e    state_q, state_d;
    logic [2:0]      exp_idx_q, exp_idx_d;
    logic [23:0]     dig_sh_q, dig_sh_d;
    logic [5:0]      dp_sh_q, dp_sh_d;
    logic [5:0]      bad_sh_q, bad_sh_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic [23:0] digits_q;
    logic [5:0]  dp_q, bad_q;
    logic        frame_valid_q, changed_q, seq_err_q, link_lost_q;

    logic       cap_valid, to_hit, commit, seq_err_d, frame_changed;
    logic [2:0] cap_idx;
    logic [3:0] cap_digit;

    assign cap_valid = cap_stb && sel_is_onehot(cap_sel);
    assign cap_idx   = sel_to_idx(cap_sel);
    assign cap_digit = seg_decode(cap_seg[7:1]);
    // A capture in the timeout cycle keeps the link alive.
    assign to_hit    = !cap_valid && (to_cnt_q == TO_HIT);

    always_comb begin
        state_d   = state_q;
        exp_idx_d = exp_idx_q;
        dig_sh_d  = dig_sh_q;
        dp_sh_d   = dp_sh_q;
        bad_sh_d  = bad_sh_q;
        commit    = 1'b0;
        seq_err_d = 1'b0;

        if (to_hit) begin
            state_d   = ST_IDLE;
            exp_idx_d = 3'd0;
            dig_sh_d  = '0;
            dp_sh_d   = '0;
            bad_sh_d  = '0;
        end else if (cap_valid) begin
            if (state_q == ST_COLLECT && cap_idx != exp_idx_q) begin
                seq_err_d = 1'b1;
            end
            if (cap_idx == 3'd0) begin
                // Position 1 always opens a fresh frame, in or out of order.
                state_d   = ST_COLLECT;
                exp_idx_d = 3'd1;
                dig_sh_d  = {20'd0, cap_digit};
                dp_sh_d   = {5'd0, cap_seg[0]};
                bad_sh_d  = {5'd0, (cap_digit == 4'hF)};
            end else if (state_q == ST_COLLECT) begin
                if (cap_idx == exp_idx_q) begin
                    dig_sh_d[int'(cap_idx)*4 +: 4] = cap_digit;
                    dp_sh_d[cap_idx]               = cap_seg[0];
                    bad_sh_d[cap_idx]              = (cap_digit == 4'hF);
                    if (exp_idx_q == LAST_IDX) begin
                        commit    = 1'b1;
                        exp_idx_d = 3'd0;
                    end else begin
                        exp_idx_d = exp_idx_q + 3'd1;
                    end
                end else begin
                    state_d   = ST_IDLE;
                    exp_idx_d = 3'd0;
                    dig_sh_d  = '0;
                    dp_sh_d   = '0;
                    bad_sh_d  = '0;
                end
            end
        end
    end

    assign frame_changed = ({dig_sh_d, dp_sh_d} != {digits_q, dp_q});

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (cap_valid) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            state_q       <= ST_IDLE;
            exp_idx_q     <= 3'd0;
            dig_sh_q      <= '0;
            dp_sh_q       <= '0;
            bad_sh_q      <= '0;
            to_cnt_q      <= '0;
            digits_q      <= '0;
            dp_q          <= '0;
            bad_q         <= '0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            link_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_idx_q     <= exp_idx_d;
            dig_sh_q      <= dig_sh_d;
            dp_sh_q       <= dp_sh_d;
            bad_sh_q      <= bad_sh_d;
            to_cnt_q      <= to_cnt_d;
            frame_valid_q <= commit;
            changed_q     <= commit && frame_changed;
            seq_err_q     <= seq_err_d;
            if (commit) begin
                digits_q    <= dig_sh_d;
                dp_q        <= dp_sh_d;
                bad_q       <= bad_sh_d;
                link_lost_q <= 1'b0;
            end else if (to_hit) begin
                link_lost_q <= 1'b1;
            end
        end
    end

    assign digits_o      = digits_q;
    assign dp_o          = dp_q;
    assign bad_code_o    = bad_q;
    assign frame_valid_o = frame_valid_q;
    assign changed_o     = changed_q;
    assign seq_err_o     = seq_err_q;
    assign link_lost_o   = link_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for the scan-bus readback monitor: frames, change detection,
// glitch rejection, bad glyphs, blank bus, link timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_seg_scan_decoder;
    import seg_disp_pkg::*;

    localparam int STABLE = 16;
    localparam int TOUT   = 2500;
    localparam int HOLD   = 40;

    localparam logic [7:0] A1 = 8'b10110110;
    localparam logic [7:0] A2 = 8'b11111100;
    localparam logic [7:0] A3 = 8'b01100000;
    localparam logic [7:0] A4 = 8'b11011011;
    localparam logic [7:0] A5 = 8'b11110010;
    localparam logic [7:0] A6 = 8'b01100110;

    logic        clk = 1'b0;
    logic        rst_all = 1'b1;
    logic [23:0] digits_o;
    logic [5:0]  dp_o, bad_code_o;
    logic        frame_valid_o, changed_o, seq_err_o, link_lost_o;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TOUT)) dut (
        .clk           (clk),
        .rst_all       (rst_all),
        .bus           (bus),
        .digits_o      (digits_o),
        .dp_o          (dp_o),
        .bad_code_o    (bad_code_o),
        .frame_valid_o (frame_valid_o),
        .changed_o     (changed_o),
        .seq_err_o     (seq_err_o),
        .link_lost_o   (link_lost_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   fv_cnt = 0;
    int   se_cnt = 0;
    int   stray_ch = 0;
    logic last_changed = 1'b0;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_all) begin
            if (frame_valid_o) begin
                fv_cnt       = fv_cnt + 1;
                last_changed = changed_o;
            end
            if (changed_o && !frame_valid_o) stray_ch = stray_ch + 1;
            if (seq_err_o) se_cnt = se_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sel, input logic [7:0] seg, input int n);
        bus.scan_sel_in = sel;
        bus.seg_in      = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3,
                         input logic [7:0] p4, input logic [7:0] p5, input logic [7:0] p6);
        drive(POS1, p1, HOLD);
        drive(POS2, p2, HOLD);
        drive(POS3, p3, HOLD);
        drive(POS4, p4, HOLD);
        drive(POS5, p5, HOLD);
        drive(POS6, p6, HOLD);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, se0, waited;
        bus.scan_sel_in = 6'd0;
        bus.seg_in      = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits_o), 32'h0);
        check("rst_dp", 32'(dp_o), 32'h0);
        check("rst_bad", 32'(bad_code_o), 32'h0);
        check("rst_fv", 32'(frame_valid_o), 32'h0);
        check("rst_changed", 32'(changed_o), 32'h0);
        check("rst_seq_err", 32'(seq_err_o), 32'h0);
        check("rst_link_lost", 32'(link_lost_o), 32'h0);
        rst_all = 1'b0;
        drive(6'd0, 8'd0, 5);

        // Clean frame
        fv0 = fv_cnt; se0 = se_cnt;
        frame(A1, A2, A3, A4, A5, A6);
        check("a_fv_count", 32'(fv_cnt - fv0), 32'd1);
        check("a_digits", 32'(digits_o), 32'h432105);
        check("a_dp", 32'(dp_o), 32'b001000);
        check("a_bad", 32'(bad_code_o), 32'h0);
        check("a_changed", 32'(last_changed), 32'd1);
        check("a_seq_err", 32'(se_cnt - se0), 32'd0);

        // Identical frame
        fv0 = fv_cnt;
        frame(A1, A2, A3, A4, A5, A6);
        check("b_fv_count", 32'(fv_cnt - fv0), 32'd1);
        check("b_changed", 32'(last_changed), 32'd0);

        // Position 2 changes to 1
        fv0 = fv_cnt;
        frame(A1, A3, A3, A4, A5, A6);
        check("c_fv_count", 32'(fv_cnt - fv0), 32'd1);
        check("c_changed", 32'(last_changed), 32'd1);
        check("c_digits", 32'(digits_o), 32'h432115);

        // Glitch on position 3
        fv0 = fv_cnt; se0 = se_cnt;
        drive(POS1, A1, HOLD);
        drive(POS2, A2, HOLD);
        drive(POS3, A3, 10);
        drive(POS4, A4, HOLD);
        drive(POS5, A5, HOLD);
        drive(POS6, A6, HOLD);
        check("g_seq_err", 32'(se_cnt - se0), 32'd1);
        check("g_no_frame", 32'(fv_cnt - fv0), 32'd0);
        check("g_digits_held", 32'(digits_o), 32'h432115);
        fv0 = fv_cnt;
        frame(A1, A2, A3, A4, A5, A6);
        check("g_recover_fv", 32'(fv_cnt - fv0), 32'd1);
        check("g_recover_digits", 32'(digits_o), 32'h432105);
        check("g_recover_changed", 32'(last_changed), 32'd1);

        // Bad glyphs
        frame(A1, A2, A3, A4, 8'b11111111, A6);
        check("bad8_digits", 32'(digits_o), 32'h482105);
        check("bad8_dp", 32'(dp_o), 32'b011000);
        check("bad8_bad", 32'(bad_code_o), 32'h0);
        frame(A1, A2, A3, A4, 8'b00000010, A6);
        check("badF_digits", 32'(digits_o), 32'h4F2105);
        check("badF_bad", 32'(bad_code_o), 32'b010000);
        check("badF_dp", 32'(dp_o), 32'b001000);

        // All-on then blank bus, then link timeout
        fv0 = fv_cnt; se0 = se_cnt;
        drive(6'b111111, 8'hFF, 1000);
        check("blank_no_frame", 32'(fv_cnt - fv0), 32'd0);
        check("blank_no_seq_err", 32'(se_cnt - se0), 32'd0);
        check("blank_link_ok", 32'(link_lost_o), 32'd0);
        bus.scan_sel_in = 6'd0;
        bus.seg_in      = 8'd0;
        waited = 0;
        while (!link_lost_o && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("link_lost_set", 32'(link_lost_o), 32'd1);
        check("link_lost_not_early", 32'(waited > 1000), 32'd1);
        check("timeout_no_seq_err", 32'(se_cnt - se0), 32'd0);
        fv0 = fv_cnt;
        drive(POS1, A1, HOLD);
        drive(POS2, A2, HOLD);
        drive(POS3, A3, HOLD);
        drive(POS4, A4, HOLD);
        drive(POS5, A5, HOLD);
        check("link_lost_held", 32'(link_lost_o), 32'd1);
        drive(POS6, A6, HOLD);
        check("link_fv", 32'(fv_cnt - fv0), 32'd1);
        check("link_lost_clear", 32'(link_lost_o), 32'd0);

        // Reset in the middle of a frame
        drive(POS1, A1, HOLD);
        drive(POS2, A2, HOLD);
        drive(POS3, A3, HOLD);
        drive(POS4, A4, HOLD);
        rst_all = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mrst_digits", 32'(digits_o), 32'h0);
        check("mrst_dp", 32'(dp_o), 32'h0);
        check("mrst_bad", 32'(bad_code_o), 32'h0);
        check("mrst_link", 32'(link_lost_o), 32'h0);
        rst_all = 1'b0;
        fv0 = fv_cnt; se0 = se_cnt;
        drive(POS4, A4, HOLD);
        drive(POS5, A5, HOLD);
        drive(POS6, A6, HOLD);
        check("mrst_no_frame", 32'(fv_cnt - fv0), 32'd0);
        check("mrst_no_seq_err", 32'(se_cnt - se0), 32'd0);
        frame(A1, A2, A3, A4, A5, A6);
        check("mrst_fv", 32'(fv_cnt - fv0), 32'd1);
        check("mrst_digits_after", 32'(digits_o), 32'h432105);
        check("mrst_changed", 32'(last_changed), 32'd1);
        check("no_stray_changed", 32'(stray_ch), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
